// File: rtl/trax_move_tx_if.sv
// trax_move_tx_if: byte-stream valid/ready link from the move transmitter to the UART/host side
interface trax_move_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/trax_move_tx.sv
// trax_move_tx: serialises a Trax move as ASCII notation (col, row digits, tile); MOVE_TX_TERM_EN appends CR LF
module trax_move_tx #(
    parameter int COL_W = 5,
    parameter int ROW_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_start,
    input  logic [COL_W-1:0]   move_col,
    input  logic [ROW_W-1:0]   move_row,
    input  logic [1:0]         move_tile,
    trax_move_tx_if.master     tx,
    output logic               busy,
    output logic               done,
    output logic               err
);
`ifdef MOVE_TX_TERM_EN
    typedef enum logic [3:0] {IDLE, CHECK, CONV, SEND_COL, SEND_TENS, SEND_ONES, SEND_TILE, SEND_CR, SEND_LF, FIN} state_t;
`else
    typedef enum logic [3:0] {IDLE, CHECK, CONV, SEND_COL, SEND_TENS, SEND_ONES, SEND_TILE, FIN} state_t;
`endif
    state_t             state;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   rem;
    logic [1:0]         tile_q;
    logic [3:0]         tens;
    logic [7:0]         col_char, tens_char, ones_char, tile_char;
    assign col_char  = 8'h40 + 8'(col_q);
    assign tens_char = 8'h30 + {4'h0, tens};
    assign ones_char = 8'h30 + 8'(rem);
    assign tile_char = tile_q == 2'd0 ? 8'h2B : tile_q == 2'd1 ? 8'h2F : 8'h5C;
    // Frame sequencer: validates, converts row by repeated subtraction, then streams bytes with held data
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            col_q       <= '0;
            rem         <= '0;
            tile_q      <= '0;
            tens        <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (move_start) begin
                    col_q  <= move_col;
                    rem    <= move_row;
                    tile_q <= move_tile;
                    busy   <= 1'b1;
                    state  <= CHECK;
                end
                CHECK: if (col_q > COL_W'(26) || rem > ROW_W'(99) || tile_q == 2'd3) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    tens  <= '0;
                    state <= CONV;
                end
                CONV: if (rem >= ROW_W'(10)) begin
                    rem  <= rem - ROW_W'(10);
                    tens <= tens + 4'd1;
                end else begin
                    tx.tx_valid <= 1'b1;
                    tx.tx_data  <= col_char;
                    state       <= SEND_COL;
                end
                SEND_COL: if (tx.tx_ready) begin
                    tx.tx_data <= tens != 4'd0 ? tens_char : ones_char;
                    state      <= tens != 4'd0 ? SEND_TENS : SEND_ONES;
                end
                SEND_TENS: if (tx.tx_ready) begin
                    tx.tx_data <= ones_char;
                    state      <= SEND_ONES;
                end
                SEND_ONES: if (tx.tx_ready) begin
                    tx.tx_data <= tile_char;
                    state      <= SEND_TILE;
                end
`ifdef MOVE_TX_TERM_EN
                SEND_TILE: if (tx.tx_ready) begin
                    tx.tx_data <= 8'h0D;
                    state      <= SEND_CR;
                end
                SEND_CR: if (tx.tx_ready) begin
                    tx.tx_data <= 8'h0A;
                    state      <= SEND_LF;
                end
                SEND_LF: if (tx.tx_ready) begin
                    tx.tx_valid <= 1'b0;
                    done        <= 1'b1;
                    state       <= FIN;
                end
`else
                SEND_TILE: if (tx.tx_ready) begin
                    tx.tx_valid <= 1'b0;
                    done        <= 1'b1;
                    state       <= FIN;
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trax_move_tx.sv
// tb_trax_move_tx: directed checks of move serialisation, backpressure, illegal moves and reset
module tb_trax_move_tx;
`ifdef MOVE_TX_TERM_EN
    localparam int TERM_N = 2;
`else
    localparam int TERM_N = 0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_start = 1'b0;
    logic [4:0] move_col = '0;
    logic [6:0] move_row = '0;
    logic [1:0] move_tile = '0;
    logic       busy, done, err;
    int         checks = 0;
    int         errors = 0;
    trax_move_tx_if tx();
    trax_move_tx dut (
        .clk(clk), .reset(reset), .move_start(move_start), .move_col(move_col),
        .move_row(move_row), .move_tile(move_tile), .tx(tx),
        .busy(busy), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic start_move(input logic [4:0] c, input logic [6:0] r, input logic [1:0] t);
        @(negedge clk);
        move_col = c; move_row = r; move_tile = t; move_start = 1'b1;
        @(negedge clk);
        move_start = 1'b0;
        check("busy_after_start", busy, 1);
        check("check_no_valid", tx.tx_valid, 0);
    endtask
    // iteration 0 is the CHECK-state negedge; expects first valid at 1 + floor(row/10) + 1
    task automatic run_frame(input logic [31:0] bytes, input int n, input int stall, input int exp_lat, input int poke);
        int idx, w, first, tail, total;
        logic [7:0] eb;
        bit saw_err, saw_done;
        total = n + TERM_N;
        idx = 0; w = 0; first = -1; tail = 0; saw_err = 0; saw_done = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc == poke) begin
                move_col = 5'd27; move_start = 1'b1;
            end else move_start = 1'b0;
            saw_err |= err;
            if (tail == 1) begin
                check("done_pulse", done, 1);
                check("fin_valid_low", tx.tx_valid, 0);
                check("fin_busy", busy, 1);
                tail = 2;
            end else if (tail == 2) begin
                check("done_single", done, 0);
                check("idle_busy_low", busy, 0);
                break;
            end else begin
                saw_done |= done;
                if (tx.tx_valid) begin
                    if (first < 0) first = cyc;
                    eb = idx < n ? bytes[31-8*idx -: 8] : (idx == n ? 8'h0D : 8'h0A);
                    check($sformatf("byte%0d", idx), tx.tx_data, eb);
                    if (w < stall) begin
                        tx.tx_ready = 1'b0; w++;
                    end else begin
                        tx.tx_ready = 1'b1; w = 0; idx++;
                        if (idx == total) tail = 1;
                    end
                end else begin
                    tx.tx_ready = 1'b0;
                    if (first >= 0) check("valid_gap", tx.tx_valid, 1);
                end
            end
            @(negedge clk);
        end
        move_start = 1'b0;
        tx.tx_ready = 1'b0;
        check("frame_complete", tail, 2);
        check("first_latency", first, exp_lat);
        check("no_err_in_frame", {31'd0, saw_err}, 0);
        check("no_early_done", {31'd0, saw_done}, 0);
    endtask
    initial begin
        tx.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_data", tx.tx_data, 0);
        check("rst_valid", tx.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        start_move(5'd1, 7'd2, 2'd0);
        run_frame({8'h41, 8'h32, 8'h2B, 8'h00}, 3, 0, 2, -1);
        start_move(5'd0, 7'd0, 2'd1);
        run_frame({8'h40, 8'h30, 8'h2F, 8'h00}, 3, 0, 2, -1);
        start_move(5'd26, 7'd99, 2'd2);
        run_frame({8'h5A, 8'h39, 8'h39, 8'h5C}, 4, 0, 11, 3);
        repeat (3) begin
            @(negedge clk);
            check("ignored_start_busy", busy, 0);
            check("ignored_start_err", err, 0);
        end
        start_move(5'd3, 7'd45, 2'd1);
        run_frame({8'h43, 8'h34, 8'h35, 8'h2F}, 4, 2, 6, -1);
        start_move(5'd27, 7'd5, 2'd0);
        @(negedge clk);
        check("ill_col_err", err, 1);
        check("ill_col_valid", tx.tx_valid, 0);
        check("ill_col_busy", busy, 0);
        check("ill_col_done", done, 0);
        @(negedge clk);
        check("ill_col_err_once", err, 0);
        start_move(5'd4, 7'd100, 2'd0);
        @(negedge clk);
        check("ill_row_err", err, 1);
        check("ill_row_valid", tx.tx_valid, 0);
        @(negedge clk);
        check("ill_row_err_once", err, 0);
        check("ill_row_valid2", tx.tx_valid, 0);
        start_move(5'd4, 7'd5, 2'd3);
        @(negedge clk);
        check("ill_tile_err", err, 1);
        check("ill_tile_done", done, 0);
        @(negedge clk);
        check("ill_tile_err_once", err, 0);
        check("ill_tile_valid", tx.tx_valid, 0);
        start_move(5'd3, 7'd45, 2'd1);
        tx.tx_ready = 1'b1;
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 30; i++) begin
                if (tx.tx_valid && tx.tx_data == 8'h34) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            check("reach_tens_byte", {31'd0, found}, 1);
        end
        reset = 1'b1;
        tx.tx_ready = 1'b0;
        @(negedge clk);
        check("midrst_valid", tx.tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_done2", done, 0);
        check("midrst_busy2", busy, 0);
        start_move(5'd1, 7'd2, 2'd0);
        run_frame({8'h41, 8'h32, 8'h2B, 8'h00}, 3, 0, 2, -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
